// File: rtl/wrr_arb_pkg.sv
// wrr_arb_pkg
// Shared definitions for the weighted round-robin arbiter:
//   - default parameter constants
//   - arbiter FSM state encoding
//   - wrap-around increment helper used to advance the priority pointer
package wrr_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_MAX_HOLD = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Next index after idx, wrapping to 0 past n-1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 32'd1;
        return (nxt >= n) ? 32'd0 : nxt;
    endfunction

endpackage

// File: rtl/wrr_pick.sv
// wrr_pick
// Combinational rotating priority picker. Finds the first set bit of req
// searching upward from start, wrapping around to bit 0.
// Two passes: lowest set bit at or above start (masked pass); if none,
// lowest set bit overall (unmasked pass, i.e. the wrapped part).
// Ports:
//   req         in   NUM_REQ       request vector
//   start       in   clog2(NUM_REQ) search start index
//   pick_onehot out  NUM_REQ       one-hot winner, zero if no request
//   pick_idx    out  clog2(NUM_REQ) winner index, zero if no request
//   pick_valid  out  1             any request present
module wrr_pick
    import wrr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IW-1:0]      pick_idx,
    output logic               pick_valid
);

    logic          hi_found_s;
    logic [IW-1:0] hi_idx_s;
    logic          lo_found_s;
    logic [IW-1:0] lo_idx_s;

    // Masked and unmasked lowest-set-bit searches in a single sweep.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = {IW{1'b0}};
        lo_found_s = 1'b0;
        lo_idx_s   = {IW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_idx_s   = (req[i] && !hi_found_s && (32'(i) >= 32'(start))) ? IW'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (req[i] && (32'(i) >= 32'(start)));
            lo_idx_s   = (req[i] && !lo_found_s) ? IW'(i) : lo_idx_s;
            lo_found_s = lo_found_s | req[i];
        end
    end

    assign pick_valid  = lo_found_s;
    assign pick_idx    = hi_found_s ? hi_idx_s : lo_idx_s;
    assign pick_onehot = lo_found_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx)
                                    : {NUM_REQ{1'b0}};

endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter
// Weighted round-robin arbiter with transaction hold. A grant is held until
// the grantee raises last_in (or drops its request). Each requester may win
// up to its weight of consecutive transactions before priority rotates.
// Optional build macro WRR_TIMEOUT_EN adds a hold-cycle limit (MAX_HOLD)
// that forcibly releases a stuck grant and pulses timeout_out.
// Ports:
//   clk             in   1                   clock, posedge
//   rstN            in   1                   synchronous active-low reset
//   req_in          in   NUM_REQ             level request vector
//   last_in         in   NUM_REQ             final beat, used for grantee only
//   weight_in       in   NUM_REQ*WEIGHT_W    per-requester weights
//   grant_out       out  NUM_REQ             registered one-hot grant
//   grant_valid_out out  1                   any grant
//   grant_id_out    out  clog2(NUM_REQ)      grantee index, 0 when idle
//   timeout_out     out  1                   forced-release pulse
module wrr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ-1:0]            last_in,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   weight_in,
    output logic [NUM_REQ-1:0]            grant_out,
    output logic                          grant_valid_out,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_out,
    output logic                          timeout_out
);

    localparam int IW = $clog2(NUM_REQ);

    state_t                state_r,   state_nxt_s;
    logic [NUM_REQ-1:0]    grant_r,   grant_nxt_s;
    logic [IW-1:0]         id_r,      id_nxt_s;
    logic [IW-1:0]         ptr_r,     ptr_nxt_s;
    logic [IW-1:0]         owner_r,   owner_nxt_s;
    logic [WEIGHT_W-1:0]   credit_r,  credit_nxt_s;
    logic                  timeout_r, timeout_nxt_s;

    logic [NUM_REQ-1:0]    pick_onehot_s;
    logic [IW-1:0]         pick_idx_s;
    logic                  pick_valid_s;
    logic [WEIGHT_W-1:0]   weight_sel_s;
    logic [WEIGHT_W-1:0]   weight_eff_s;
    logic [WEIGHT_W-1:0]   credit_dec_s;
    logic [IW-1:0]         ptr_succ_s;
    logic                  grantee_req_s;
    logic                  grantee_last_s;
    logic                  hold_hit_s;

    wrr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req         (req_in),
        .start       (ptr_r),
        .pick_onehot (pick_onehot_s),
        .pick_idx    (pick_idx_s),
        .pick_valid  (pick_valid_s)
    );

    assign weight_sel_s   = weight_in[32'(pick_idx_s)*WEIGHT_W +: WEIGHT_W];
    // A zero weight still allows one transaction.
    assign weight_eff_s   = (weight_sel_s == {WEIGHT_W{1'b0}}) ? WEIGHT_W'(1) : weight_sel_s;
    assign credit_dec_s   = credit_r - WEIGHT_W'(1);
    assign ptr_succ_s     = IW'(wrap_inc(32'(id_r), NUM_REQ));
    assign grantee_req_s  = req_in[id_r];
    assign grantee_last_s = last_in[id_r];

`ifdef WRR_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_cnt_r, hold_cnt_nxt_s;

    assign hold_hit_s = (hold_cnt_r == HW'(MAX_HOLD - 1));

    // Hold counter: zero while idle (so it is clear on grant), counts BUSY cycles.
    always_comb begin
        hold_cnt_nxt_s = {HW{1'b0}};
        if (state_r == BUSY) begin
            hold_cnt_nxt_s = hold_cnt_r + HW'(1);
        end else begin
            hold_cnt_nxt_s = {HW{1'b0}};
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            hold_cnt_r <= {HW{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end
`else
    logic unused_hold_s;

    assign hold_hit_s    = 1'b0;
    assign unused_hold_s = ^(32'(MAX_HOLD));
`endif

    // Next-state, grant, credit and pointer logic.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        id_nxt_s      = id_r;
        ptr_nxt_s     = ptr_r;
        owner_nxt_s   = owner_r;
        credit_nxt_s  = credit_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = BUSY;
                    grant_nxt_s = pick_onehot_s;
                    id_nxt_s    = pick_idx_s;
                    // Same owner with credit left keeps its burst going.
                    if ((pick_idx_s == owner_r) && (credit_r != {WEIGHT_W{1'b0}})) begin
                        credit_nxt_s = credit_r;
                    end else begin
                        owner_nxt_s  = pick_idx_s;
                        credit_nxt_s = weight_eff_s;
                    end
                end else begin
                    grant_nxt_s = {NUM_REQ{1'b0}};
                    id_nxt_s    = {IW{1'b0}};
                end
            end
            BUSY: begin
                if (grantee_last_s) begin
                    // Normal release; last wins even if the request dropped.
                    state_nxt_s  = IDLE;
                    grant_nxt_s  = {NUM_REQ{1'b0}};
                    id_nxt_s     = {IW{1'b0}};
                    credit_nxt_s = credit_dec_s;
                    ptr_nxt_s    = (credit_dec_s == {WEIGHT_W{1'b0}}) ? ptr_succ_s : id_r;
                end else if (!grantee_req_s || hold_hit_s) begin
                    // Abort or forced release: forfeit remaining credit.
                    state_nxt_s   = IDLE;
                    grant_nxt_s   = {NUM_REQ{1'b0}};
                    id_nxt_s      = {IW{1'b0}};
                    credit_nxt_s  = {WEIGHT_W{1'b0}};
                    ptr_nxt_s     = ptr_succ_s;
                    timeout_nxt_s = grantee_req_s & hold_hit_s;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {NUM_REQ{1'b0}};
                id_nxt_s    = {IW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r   <= IDLE;
            grant_r   <= {NUM_REQ{1'b0}};
            id_r      <= {IW{1'b0}};
            ptr_r     <= {IW{1'b0}};
            owner_r   <= {IW{1'b0}};
            credit_r  <= {WEIGHT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            id_r      <= id_nxt_s;
            ptr_r     <= ptr_nxt_s;
            owner_r   <= owner_nxt_s;
            credit_r  <= credit_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign grant_out       = grant_r;
    assign grant_valid_out = |grant_r;
    assign grant_id_out    = id_r;
    assign timeout_out     = timeout_r;

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter
// Directed self-checking bench for wrr_arbiter (NUM_REQ=4, WEIGHT_W=4,
// MAX_HOLD=8). The timeout scenario runs only when WRR_TIMEOUT_EN is defined.
module tb_wrr_arbiter;

    localparam int HOLD_CYCLES =
`ifdef WRR_TIMEOUT_EN
        6;
`else
        20;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  req_in;
    logic [3:0]  last_in;
    logic [15:0] weight_in;
    logic [3:0]  grant_out;
    logic        grant_valid_out;
    logic [1:0]  grant_id_out;
    logic        timeout_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wrr_arbiter #(
        .NUM_REQ  (4),
        .WEIGHT_W (4),
        .MAX_HOLD (8)
    ) dut (
        .clk             (clk),
        .rstN            (rstN),
        .req_in          (req_in),
        .last_in         (last_in),
        .weight_in       (weight_in),
        .grant_out       (grant_out),
        .grant_valid_out (grant_valid_out),
        .grant_id_out    (grant_id_out),
        .timeout_out     (timeout_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN    = 1'b0;
        req_in  = 4'b0000;
        last_in = 4'b0000;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        weight_in = {4'd3, 4'd1, 4'd2, 4'd1};
        do_reset();
        checks++;
        if (grant_out !== 4'b0000 || grant_valid_out !== 1'b0 ||
            grant_id_out !== 2'd0 || timeout_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got grant=%b valid=%b id=%0d to=%b want 0000 0 0 0",
                     grant_out, grant_valid_out, grant_id_out, timeout_out);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (grant_out !== 4'b0000 || grant_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_req cyc%0d: got grant=%b valid=%b want 0000 0",
                         i, grant_out, grant_valid_out);
            end
        end
        req_in = 4'b0001;
        tick();
        checks++;
        if (grant_out !== 4'b0001 || grant_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_grant: got %b want 0001", grant_out);
        end
        rstN = 1'b0;
        tick();
        checks++;
        if (grant_out !== 4'b0000 || grant_id_out !== 2'd0 || grant_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy: got grant=%b id=%0d want 0000 0", grant_out, grant_id_out);
        end
        rstN   = 1'b1;
        req_in = 4'b0000;
        tick();
    endtask

    task automatic test_weighted();
        int         exp_ids [10];
        logic [3:0] want;
        exp_ids = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1};
        weight_in = {4'd3, 4'd1, 4'd2, 4'd1};
        do_reset();
        req_in = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            want = 4'b0001 << exp_ids[k];
            tick();
            checks++;
            if (grant_out !== want || grant_id_out !== 2'(exp_ids[k]) || grant_valid_out !== 1'b1) begin
                errors++;
                $display("FAIL weighted_grant #%0d: got grant=%b id=%0d want %b id=%0d",
                         k, grant_out, grant_id_out, want, exp_ids[k]);
            end
            last_in = want;
            tick();
            last_in = 4'b0000;
            checks++;
            if (grant_out !== 4'b0000 || grant_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL weighted_bubble #%0d: got %b want 0000", k, grant_out);
            end
        end
        req_in = 4'b0000;
        tick();
    endtask

    task automatic test_hold();
        weight_in = {4'd3, 4'd1, 4'd2, 4'd1};
        do_reset();
        req_in = 4'b0100;
        tick();
        checks++;
        if (grant_out !== 4'b0100) begin
            errors++;
            $display("FAIL hold_first: got %b want 0100", grant_out);
        end
        req_in  = 4'b1111;
        last_in = 4'b0010;
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            tick();
            checks++;
            if (grant_out !== 4'b0100 || grant_id_out !== 2'd2 || timeout_out !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got grant=%b id=%0d to=%b want 0100 2 0",
                         i, grant_out, grant_id_out, timeout_out);
            end
        end
        last_in = 4'b0100;
        tick();
        checks++;
        if (grant_out !== 4'b0000) begin
            errors++;
            $display("FAIL hold_release: got %b want 0000", grant_out);
        end
        req_in  = 4'b0000;
        last_in = 4'b0000;
        tick();
    endtask

    task automatic test_abort();
        weight_in = {4'd3, 4'd1, 4'd2, 4'd1};
        do_reset();
        req_in = 4'b0010;
        tick();
        checks++;
        if (grant_out !== 4'b0010 || grant_id_out !== 2'd1) begin
            errors++;
            $display("FAIL abort_grant1: got grant=%b id=%0d want 0010 1", grant_out, grant_id_out);
        end
        req_in = 4'b0100;
        tick();
        checks++;
        if (grant_out !== 4'b0000 || grant_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: got %b want 0000", grant_out);
        end
        req_in = 4'b0110;
        tick();
        checks++;
        if (grant_out !== 4'b0100 || grant_id_out !== 2'd2) begin
            errors++;
            $display("FAIL abort_next: got grant=%b id=%0d want 0100 2", grant_out, grant_id_out);
        end
        last_in = 4'b0100;
        tick();
        req_in  = 4'b0000;
        last_in = 4'b0000;
        tick();
    endtask

    task automatic test_wrap_skip();
        weight_in = {4'd1, 4'd1, 4'd2, 4'd1};
        do_reset();
        // Grant 2 with weight 1 so the pointer lands on 3.
        req_in = 4'b0100;
        tick();
        last_in = 4'b0100;
        tick();
        last_in = 4'b0000;
        req_in  = 4'b0010;
        tick();
        checks++;
        if (grant_out !== 4'b0010 || grant_id_out !== 2'd1) begin
            errors++;
            $display("FAIL skip_to_1: got grant=%b id=%0d want 0010 1", grant_out, grant_id_out);
        end
        last_in = 4'b0010;
        tick();
        last_in = 4'b0000;
        req_in  = 4'b1000;
        tick();
        checks++;
        if (grant_out !== 4'b1000 || grant_id_out !== 2'd3) begin
            errors++;
            $display("FAIL grant_3: got grant=%b id=%0d want 1000 3", grant_out, grant_id_out);
        end
        last_in = 4'b1000;
        tick();
        last_in = 4'b0000;
        req_in  = 4'b1001;
        tick();
        checks++;
        if (grant_out !== 4'b0001 || grant_id_out !== 2'd0) begin
            errors++;
            $display("FAIL wrap_to_0: got grant=%b id=%0d want 0001 0", grant_out, grant_id_out);
        end
        last_in = 4'b0001;
        tick();
        req_in  = 4'b0000;
        last_in = 4'b0000;
        tick();
    endtask

`ifdef WRR_TIMEOUT_EN
    task automatic test_timeout();
        weight_in = {4'd3, 4'd1, 4'd2, 4'd1};
        do_reset();
        req_in = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (grant_out !== 4'b0001 || timeout_out !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold cyc%0d: got grant=%b to=%b want 0001 0",
                         i, grant_out, timeout_out);
            end
        end
        tick();
        checks++;
        if (grant_out !== 4'b0000 || timeout_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: got grant=%b to=%b want 0000 1", grant_out, timeout_out);
        end
        tick();
        checks++;
        if (grant_out !== 4'b0010 || timeout_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next: got grant=%b to=%b want 0010 0", grant_out, timeout_out);
        end
        req_in = 4'b0000;
        tick();
        tick();
    endtask
`endif

    initial begin
        rstN      = 1'b0;
        req_in    = 4'b0000;
        last_in   = 4'b0000;
        weight_in = 16'h0000;
        test_reset();
        test_weighted();
        test_hold();
        test_abort();
        test_wrap_skip();
`ifdef WRR_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Weighted round-robin arbiter with transaction hold; successor to the single-cycle round-robin arbiter.
- Grants one of NUM_REQ requesters.
- Holds the grant across a multi-cycle transaction until the grantee signals last_in.
- Lets each requester win up to its programmed weight of consecutive transactions before priority rotates.
- Sits in front of shared buses and memory ports in the log pipeline.

Parameters:
NUM_REQ, 4, number of requesters (2..32)
WEIGHT_W, 4, width of each per-requester weight field
MAX_HOLD, 64, cycle limit for one grant (used only with WRR_TIMEOUT_EN)

Ports:
clk  input  1  clock; all logic on posedge
rstN  input  1  reset, synchronous, active-low
req_in  input  NUM_REQ  request vector, level-sensitive
last_in  input  NUM_REQ  final-beat indication per requester; honoured only for the current grantee
weight_in  input  NUM_REQ*WEIGHT_W  weight of requester i at [i*WEIGHT_W +: WEIGHT_W]; quasi-static
grant_out  output  NUM_REQ  one-hot registered grant, or all zero
grant_valid_out  output  1  OR of grant_out
grant_id_out  output  $clog2(NUM_REQ)  index of grantee; 0 when no grant
timeout_out  output  1  one-cycle pulse on forced release (tied 0 without WRR_TIMEOUT_EN)

Behaviour:
- Reset (rstN=0 at posedge): state IDLE, grant_out=0, grant_valid_out=0, grant_id_out=0, timeout_out=0, ptr=0, credit=0, owner=0.
- FSM has 2 states.
- IDLE:
  - If req_in==0, stay in IDLE; outputs stay 0.
  - Otherwise pick the first set bit of req_in searching upward from ptr with wrap.
  - Register the grant: grant_out is one-hot on the next cycle, state -> BUSY.
  - Latency: request to grant is 1 cycle.
- Credit:
  - If the pick == owner and credit>0, credit is unchanged.
  - Otherwise owner<=pick and credit<=weight of pick.
  - A weight of 0 is treated as 1.
- BUSY, grant held to g:
  - While req_in[g]=1 and last_in[g]=0, the grant holds.
  - Changes on other req bits are ignored.
  - last_in bits of non-grantees are ignored.
- Release on last_in[g]=1:
  - Next cycle grant_out=0 and state IDLE. There is exactly one bubble cycle between back-to-back grants.
  - credit<=credit-1.
  - If the new credit==0: ptr<=(g+1) mod NUM_REQ.
  - Otherwise ptr<=g, so g keeps priority next arbitration if still requesting.
- Abort (req_in[g]=0 in BUSY without last_in[g]):
  - Release as above.
  - credit<=0 and ptr<=(g+1) mod NUM_REQ.
- Simultaneous last_in[g] and req_in[g]=0: treated as a normal release, not an abort.
- Wrap: when g=NUM_REQ-1, ptr goes to 0.
- If ptr's requester is idle, the search skips it. Its leftover credit is discarded because the pick differs from owner.
- Reset mid-BUSY: the grant drops on the next cycle and all state returns to reset values. No last_in is required.
- A weight_in change takes effect only at the next credit reload.

Optional Feature:
WRR_TIMEOUT_EN
- Defined:
  - A hold counter clears on grant and increments every BUSY cycle.
  - When it reaches MAX_HOLD-1 without a release, the grant is forcibly released, with abort semantics.
  - timeout_out pulses high for 1 cycle, aligned with grant_out going 0.
- Undefined: no counter is built, timeout_out=0, and the grant can be held indefinitely.

Decomposition:
- Package wrr_arb_pkg holds:
  - state enum (IDLE, BUSY)
  - the helper function for the wrap-around increment of ptr
  - the default parameter constants
- One natural sub-module: wrr_pick.
  - Combinational, parameterised by NUM_REQ.
  - Inputs: req vector and start index.
  - Outputs: one-hot pick, index, any-valid.
  - Implementation: two-pass priority search (masked, then unmasked).

Test Plan:
1. Reset, then req_in=4'b0000 -> grant_out=0 for 10 cycles; assert rstN mid-BUSY -> grant_out=0 the cycle after.
2. Weights {w3,w2,w1,w0}={3,1,2,1}; req_in=4'b1111 held; last_in pulsed on the first grant cycle of each grant -> grant_id sequence 0,1,1,2,3,3,3,0,1,1; one idle cycle between grants.
3. Grant to 2 with req_in=4'b0100, last_in held low for 20 cycles while req_in=4'b1111 -> grant_out stays 4'b0100; last_in[1] pulses are ignored.
4. Abort: grant to 1 (weight 2), drop req_in[1] without last -> release next cycle; next grant goes to 2, not 1.
5. Wrap and skip: ptr=3, req_in=4'b0010 -> grant to 1 after 1 cycle; only req_in[3]=1 with weight 1 -> grant 3, then ptr wraps to 0.
6. With WRR_TIMEOUT_EN, MAX_HOLD=8: grant held, no last -> forced release after 8 BUSY cycles; timeout_out high for exactly 1 cycle; next grant goes to the next requester.
